alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the datapath ALU.
- Keeps the existing single-cycle opcode set and registers every result behind a valid/ready handshake.
- Adds a proper NZCV flag set and an iterative shift-add multiplier; an iterative unsigned divider is optional.
- Sits in the EX stage; the pipeline control stalls on in_ready/out_valid.

---
 rtl/alu_mc_pkg.sv | 36 +++
 rtl/alu_mc_iter.sv | 107 ++++++++++
 rtl/alu_mc.sv | 148 ++++++++++++++
 tb/tb_alu_mc.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the multi-cycle ALU.
// ALU_MC_DIV_EN selects whether opcode 0100 runs the iterative unsigned divider.
package alu_mc_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_UDIV  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  // Opcodes that take the WIDTH-cycle iterative path instead of the one-cycle path.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    return (op == OP_MUL) || (op == OP_UDIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared shift/accumulate datapath: shift-add multiply and, with ALU_MC_DIV_EN,
// restoring unsigned divide. One iteration per clock for WIDTH clocks after start.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero
);

  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [CNT_W-1:0] cnt_r;
  logic             active_r;
  logic             last;
  logic [WIDTH:0]   mul_sum;

  // Multiply: {hi,lo} holds partial product and remaining multiplier bits, shifted right.
  assign mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : '0);

`ifdef ALU_MC_DIV_EN
  logic             is_div_r;
  logic             div_ge;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_rem;

  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  // A zero divisor always subtracts, which yields the all-ones quotient by itself.
  always_comb begin
    div_shift = {hi_r, lo_r[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_r});
    div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_r}) : div_shift[WIDTH-1:0];
  end
`else
  logic unused_op;
  assign unused_op = ^op;
`endif

  always_comb begin
    hi_nx = mul_sum[WIDTH:1];
    lo_nx = {mul_sum[0], lo_r[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    if (is_div_r) begin
      hi_nx = div_rem;
      lo_nx = {lo_r[WIDTH-2:0], div_ge};
    end
`endif
  end

  assign last   = (cnt_r == CNT_W'(WIDTH - 1));
  assign done   = active_r && last;
  assign result = lo_nx;

`ifdef ALU_MC_DIV_EN
  assign hi_nonzero = is_div_r ? (opnd_r == '0) : (hi_nx != '0);
`else
  assign hi_nonzero = (hi_nx != '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r <= 1'b0;
      cnt_r    <= '0;
      opnd_r   <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
`ifdef ALU_MC_DIV_EN
      is_div_r <= 1'b0;
`endif
    end else if (start) begin
      active_r <= 1'b1;
      cnt_r    <= '0;
      hi_r     <= '0;
      opnd_r   <= data_a;
      lo_r     <= data_b;
`ifdef ALU_MC_DIV_EN
      is_div_r <= (op == OP_UDIV);
      if (op == OP_UDIV) begin
        opnd_r <= data_b;
        lo_r   <= data_a;
      end
`endif
    end else if (active_r) begin
      hi_r <= hi_nx;
      lo_r <= lo_nx;
      if (last) begin
        active_r <= 1'b0;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: one-cycle logic/add/sub ops, iterative MUL, and
// iterative UDIV when ALU_MC_DIV_EN is defined. Results held behind valid/ready.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int MSB   = WIDTH - 1;

  // Handshake: an op transfers on a rising edge where in_valid && in_ready; a result
  // transfers where out_valid && out_ready. A held result never changes while
  // out_valid && !out_ready, and in_valid without in_ready is simply dropped.

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             iter_op;
  logic             start;
  logic             load_alu;
  logic             load_iter;
  logic             iter_done;
  logic             iter_hi_nz;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH:0]   sum;
  logic             known;
  flags_t           alu_flags;
  flags_t           iter_flags;
  logic [WIDTH-1:0] result_r;
  flags_t           flags_r;

  assign in_ready = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign iter_op  = is_iter_op(op);
  assign start    = accept && iter_op;

  always_comb begin
    alu_result  = '0;
    sum         = '0;
    known       = 1'b1;
    alu_flags   = '0;
    case (op)
      OP_AND:   alu_result = data_a & data_b;
      OP_OR:    alu_result = data_a | data_b;
      OP_NOR:   alu_result = ~(data_a | data_b);
      OP_PASSB: alu_result = data_b;
      OP_ADD: begin
        sum         = {1'b0, data_a} + {1'b0, data_b};
        alu_result  = sum[MSB:0];
        alu_flags.c = sum[WIDTH];
        alu_flags.v = (data_a[MSB] == data_b[MSB]) && (alu_result[MSB] != data_a[MSB]);
      end
      OP_SUB: begin
        sum         = {1'b0, data_a} + {1'b0, ~data_b} + (WIDTH + 1)'(1);
        alu_result  = sum[MSB:0];
        alu_flags.c = sum[WIDTH];
        alu_flags.v = (data_a[MSB] != data_b[MSB]) && (alu_result[MSB] != data_a[MSB]);
      end
      default:  known = 1'b0;
    endcase
    // Unrecognised opcodes report all flags clear, including Z.
    alu_flags.z = known && (alu_result == '0);
    alu_flags.n = alu_result[MSB];
  end

  always_comb begin
    iter_flags   = '0;
    iter_flags.z = (iter_result == '0);
    iter_flags.n = iter_result[MSB];
    iter_flags.v = iter_hi_nz;
  end

  always_comb begin
    state_nx  = state;
    load_alu  = accept && !iter_op;
    load_iter = (state == ST_BUSY) && iter_done;
    case (state)
      ST_IDLE: if (accept) state_nx = iter_op ? ST_BUSY : ST_DONE;
      ST_BUSY: if (iter_done) state_nx = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          if (accept) state_nx = iter_op ? ST_BUSY : ST_DONE;
          else        state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      result_r <= '0;
      flags_r  <= '0;
    end else begin
      state <= state_nx;
      if (load_alu) begin
        result_r <= alu_result;
        flags_r  <= alu_flags;
      end else if (load_iter) begin
        result_r <= iter_result;
        flags_r  <= iter_flags;
      end
    end
  end

  alu_mc_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .data_a     (data_a),
    .data_b     (data_b),
    .done       (iter_done),
    .result     (iter_result),
    .hi_nonzero (iter_hi_nz)
  );

  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_BUSY);
  assign result    = result_r;
  assign flag_z    = flags_r.z;
  assign flag_n    = flags_r.n;
  assign flag_c    = flags_r.c;
  assign flag_v    = flags_r.v;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=64) with an arithmetic reference model and scoreboard.
// Build with +define+ALU_MC_DIV_EN to exercise the divider vectors.
`timescale 1ns/1ps
module tb_alu_mc;

  localparam int W  = 64;
  localparam int EW = W + 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  vec_t vecs[9];

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_a    (data_a),
    .data_b    (data_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {result, z, n, c, v} from plain unsigned/signed arithmetic.
  function automatic logic [EW-1:0] model(input logic [3:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0]     r;
    logic             c;
    logic             v;
    logic             known;
    logic [2*W-1:0]   p;
    logic signed [W+1:0] s;
    r = '0; c = 1'b0; v = 1'b0; known = 1'b1; p = '0; s = '0;
    case (o)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0111: r = b;
      4'b0010: begin
        p = {{W{1'b0}}, a} + {{W{1'b0}}, b};
        r = p[W-1:0];
        c = p[W];
        s = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        v = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
      end
      4'b0110: begin
        r = a - b;
        c = (a >= b);
        s = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        v = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
      end
      4'b0011: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = p[W-1:0];
        v = (p[2*W-1:W] != '0);
      end
`ifdef ALU_MC_DIV_EN
      4'b0100: begin
        if (b == '0) begin
          r = '1;
          v = 1'b1;
        end else begin
          r = a / b;
        end
      end
`endif
      default: known = 1'b0;
    endcase
    return {r, known && (r == '0), r[W-1], c, v};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: out_valid=1 result=0x%0h with nothing pending", result);
        end else begin
          chk("sb_result_flags", {result, flag_z, flag_n, flag_c, flag_v}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, data_a, data_b));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    got      = 1'b0;
    op       = o;
    data_a   = a;
    data_b   = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    // Scramble operands after accept: the held op must not see them.
    op     = 4'($urandom_range(0, 15));
    data_a = {$urandom, $urandom};
    data_b = {$urandom, $urandom};
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic wait_out(output int lat, output int ready_hi, output int busy_hi);
    lat = 0; ready_hi = 0; busy_hi = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      if (in_ready) ready_hi++;
      if (busy) busy_hi++;
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: out_valid got 0, expected 1 within 300 cycles");
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_r,
                        input logic [3:0] exp_f);
    int lat, rh, bh;
    send(o, a, b);
    wait_out(lat, rh, bh);
    chk({name, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({name, "_result"}, result, exp_r);
    chk({name, "_flags"}, {flag_z, flag_n, flag_c, flag_v}, exp_f);
    if (exp_lat > 1) begin
      chk({name, "_ready_low"}, 128'(rh), 128'd0);
      chk({name, "_busy_cycles"}, 128'(bh), 128'(exp_lat - 1));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ov_cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; data_a = '0; data_b = '0;

    vecs[0] = '{4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000};
    vecs[1] = '{4'b1100, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};
    vecs[2] = '{4'b0111, 64'h5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b0100};
    vecs[3] = '{4'b0110, 64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100};
    vecs[4] = '{4'b0110, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[5] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE, 4'b0110};
    vecs[6] = '{4'b1111, 64'h1, 64'h1, 64'h0, 4'b0000};
    vecs[7] = '{4'b0101, 64'h7, 64'h7, 64'h0, 4'b0000};
    vecs[8] = '{4'b0000, 64'hFF, 64'h0, 64'h0, 4'b1000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {in_ready, out_valid, busy, flag_z, flag_n, flag_c, flag_v, result}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Signed overflow on ADD, then result drains
    run_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1, 64'h8000_0000_0000_0000, 4'b0101);
    @(negedge clk);
    chk("add_drained", out_valid, 1'b0);
    @(posedge clk); #1;

    // Back-to-back SUB then ADD: one result per cycle
    op = 4'b0110; data_a = 64'd5; data_b = 64'd5; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready0", in_ready, 1'b1);
    @(posedge clk); #1;
    op = 4'b0010; data_a = 64'hFFFF_FFFF_FFFF_FFFF; data_b = 64'd1;
    @(negedge clk);
    chk("b2b_sub_valid", out_valid, 1'b1);
    chk("b2b_ready1", in_ready, 1'b1);
    chk("b2b_sub", {result, flag_z, flag_n, flag_c, flag_v}, {64'h0, 4'b1010});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_add_valid", out_valid, 1'b1);
    chk("b2b_add", {result, flag_z, flag_n, flag_c, flag_v}, {64'h0, 4'b1010});
    @(posedge clk); #1;

    // Iterative multiply
    run_op("mul_small", 4'b0011, 64'h1234, 64'h10, W + 1, 64'h12340, 4'b0000);
    run_op("mul_ovf", 4'b0011, 64'h8000_0000_0000_0000, 64'h4, W + 1, 64'h0, 4'b1001);

    // Consumer stall: result held, new requests ignored
    out_ready = 1'b0;
    begin
      int lat, rh, bh;
      send(4'b0001, 64'hF0, 64'h0F);
      wait_out(lat, rh, bh);
      chk("or_lat", 128'(lat), 128'd1);
    end
    @(posedge clk); #1;
    op = 4'b0010; data_a = 64'd1; data_b = 64'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 64'hFF});
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_drained", out_valid, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    send(4'b0011, 64'hDEAD_BEEF, 64'h1234_5678);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {in_ready, out_valid, busy, flag_z, flag_n, flag_c, flag_v, result}, '0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release", {in_ready, out_valid, busy}, 3'b100);
    ov_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("midrst_abandoned", 128'(ov_cnt), 128'd0);
    @(posedge clk); #1;
    run_op("post_rst_add", 4'b0010, 64'd2, 64'd3, 1, 64'd5, 4'b0000);

    // Opcode 0100
`ifdef ALU_MC_DIV_EN
    run_op("udiv", 4'b0100, 64'd100, 64'd7, W + 1, 64'd14, 4'b0000);
    run_op("udiv_zero", 4'b0100, 64'd17, 64'd0, W + 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0101);
`else
    run_op("op0100_unknown", 4'b0100, 64'd100, 64'd7, 1, 64'd0, 4'b0000);
`endif

    // Directed single-cycle vectors
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1, vecs[i].r, vecs[i].f);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
